// File: rtl/float_accumulator.sv
// Window accumulator for IEEE-754 single products: sums N_TERMS terms with a truncating adder, then holds the result until it is accepted.
// Optional build macro FLOAT_ACC_RELU_EN clamps negative final sums to +0.
module float_accumulator #(
  parameter int N_TERMS = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prod_valid,
  input  logic [31:0] prod_data,
  output logic        prod_ready,
  output logic        sum_valid,
  output logic [31:0] sum_data,
  input  logic        sum_ready
);

  typedef enum logic {ACC, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sum_q, sum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] add_res, sum_res;
  logic        accept, last;

  // Denormals flush to +0, inf/NaN are sticky, alignment and normalisation truncate.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [7:0]  d, e_big;
    logic [23:0] m_big, m_shf, m_diff;
    logic [24:0] m_sum;
    logic [22:0] m_norm;
    logic [4:0]  lz;
    logic        found;
    fadd   = 32'h0;
    big    = a;
    sml    = b;
    m_sum  = '0;
    m_diff = '0;
    m_norm = '0;
    lz     = '0;
    found  = 1'b0;
    if (a[30:23] == 8'hFF) begin
      fadd = a;
    end else if (b[30:23] == 8'hFF) begin
      fadd = b;
    end else if (a[30:23] == 8'h00 && b[30:23] == 8'h00) begin
      fadd = 32'h0;
    end else if (a[30:23] == 8'h00) begin
      fadd = b;
    end else if (b[30:23] == 8'h00) begin
      fadd = a;
    end else begin
      if (a[30:0] < b[30:0]) begin
        big = b;
        sml = a;
      end
      e_big = big[30:23];
      d     = e_big - sml[30:23];
      m_big = {1'b1, big[22:0]};
      m_shf = {1'b1, sml[22:0]} >> d;
      if (d >= 8'd25) begin
        fadd = big;
      end else if (big[31] == sml[31]) begin
        m_sum = {1'b0, m_big} + {1'b0, m_shf};
        if (!m_sum[24])
          fadd = {big[31], e_big, m_sum[22:0]};
        else if (e_big == 8'hFE)
          fadd = {big[31], 8'hFF, 23'h0};
        else
          fadd = {big[31], e_big + 8'd1, m_sum[23:1]};
      end else begin
        m_diff = m_big - m_shf;
        for (int i = 23; i >= 0; i--) begin
          if (!found) begin
            if (m_diff[i]) found = 1'b1;
            else           lz = lz + 5'd1;
          end
        end
        m_norm = 23'(m_diff << lz);
        if (m_diff == 24'h0 || {3'b000, lz} >= e_big)
          fadd = 32'h0;
        else
          fadd = {big[31], e_big - {3'b000, lz}, m_norm};
      end
    end
  endfunction

  assign add_res = fadd(acc_q, prod_data);

`ifdef FLOAT_ACC_RELU_EN
  assign sum_res = (add_res[31] && !(add_res[30:23] == 8'hFF && add_res[22:0] != 23'h0))
                   ? 32'h0 : add_res;
`else
  assign sum_res = add_res;
`endif

  assign accept = prod_valid && prod_ready;
  assign last   = (cnt_q == 8'(N_TERMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && last) state_d = HOLD;
      HOLD:    if (sum_ready)      state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    prod_ready = (state_q == ACC);
    sum_valid  = (state_q == HOLD);
    sum_data   = sum_q;
  end

  // The window register is cleared only by the output handshake, so no product overlaps it.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (accept) begin
      acc_d = add_res;
      cnt_d = cnt_q + 8'd1;
      if (last) sum_d = sum_res;
    end
    if (state_q == HOLD && sum_ready) begin
      acc_d = 32'h0;
      cnt_d = 8'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 32'h0;
      cnt_q <= 8'h0;
      sum_q <= 32'h0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: tb/tb_float_accumulator.sv
// Scoreboard bench for float_accumulator: directed windows plus randomized windows checked against an integer-arithmetic reference model.
module tb_float_accumulator;
  localparam int N = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prod_valid = 1'b0;
  logic [31:0] prod_data = 32'h0;
  logic        prod_ready;
  logic        sum_valid;
  logic [31:0] sum_data;
  logic        sum_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  int sink_delay = 0;
  logic [31:0] exp_q[$];
  logic [31:0] win_terms[$];
  logic [31:0] model_acc = 32'h0;
  int          model_cnt = 0;

  float_accumulator #(.N_TERMS(N)) dut (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_ready(prod_ready), .sum_valid(sum_valid), .sum_data(sum_data),
    .sum_ready(sum_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: signed integer mantissas, truncating shifts, loop normalisation.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    longint va, vb, r, mag;
    logic s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255) return a;
    if (eb == 255) return b;
    va = (ea == 0) ? 0 : longint'({1'b1, a[22:0]});
    vb = (eb == 0) ? 0 : longint'({1'b1, b[22:0]});
    if (va == 0 && vb == 0) return 32'h0;
    if (va == 0) return b;
    if (vb == 0) return a;
    e = (ea > eb) ? ea : eb;
    va = (e - ea >= 25) ? 0 : (va >> (e - ea));
    vb = (e - eb >= 25) ? 0 : (vb >> (e - eb));
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    r = va + vb;
    if (r == 0) return 32'h0;
    s = (r < 0);
    mag = s ? -r : r;
    while (mag >= 64'd16777216) begin mag = mag >> 1; e++; end
    while (mag < 64'd8388608)   begin mag = mag << 1; e--; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e < 1) return 32'h0;
    return {s, 8'(e), mag[22:0]};
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] x);
`ifdef FLOAT_ACC_RELU_EN
    if (x[31] && !(x[30:23] == 8'hFF && x[22:0] != 0)) return 32'h0;
`endif
    return x;
  endfunction

  function automatic logic [31:0] rand_term();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4)  return 32'h0;
    if (r < 6)  return 32'h80000000;
    if (r < 8)  return {1'($urandom), 8'h00, 23'($urandom)};
    if (r == 8) return {1'($urandom), 8'hFF, 23'h0};
    if (r == 9) return 32'h7FC00000;
    return {1'($urandom), 8'($urandom_range(117, 137)), 23'($urandom)};
  endfunction

  // Presents win_terms in order; a window's expected sum is queued on its last accept.
  task automatic applyStimulus(input bit gaps, input bit use_const, input logic [31:0] const_val);
    int waited;
    while (win_terms.size() > 0) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        prod_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      prod_valid = 1'b1;
      prod_data  = win_terms[0];
      waited = 0;
      while (!prod_ready && waited < 50) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!prod_ready) begin
        checks++; errors++;
        $display("[TB] FAIL accept_timeout actual=%0d expected<50", waited);
        prod_valid = 1'b0;
        return;
      end
      model_acc = ref_add(model_acc, win_terms.pop_front());
      model_cnt++;
      if (model_cnt == N) begin
        exp_q.push_back(use_const ? const_val : ref_out(model_acc));
        pushed++;
        model_acc = 32'h0;
        model_cnt = 0;
      end
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
  endtask

  task automatic fill(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) win_terms.push_back(v);
  endtask

  // Downstream sink: raises sum_ready after sink_delay cycles of sum_valid.
  initial begin : sink
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (sum_valid && !sum_ready) begin
        if (wait_cnt >= sink_delay) sum_ready = 1'b1;
        else wait_cnt++;
      end else begin
        sum_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Monitor: pops on each new output, then checks it stays stable with prod_ready low.
  initial begin : monitor
    bit seen;
    logic [31:0] cur;
    seen = 1'b0;
    cur  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n || !sum_valid) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_sum actual=%h expected=none", sum_data);
            cur = sum_data;
          end else begin
            cur = exp_q.pop_front();
            popped++;
            checkOutput("sum_data", sum_data, cur);
          end
          seen = 1'b1;
        end else begin
          checkOutput("hold_stable", sum_data, cur);
        end
        checkOutput("hold_prod_ready", {31'h0, prod_ready}, 32'h0);
        if (sum_ready) seen = 1'b0;
      end
    end
  end

  initial begin : driver
    int waited;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_prod_ready", {31'h0, prod_ready}, 32'h1);
    checkOutput("reset_sum_valid", {31'h0, sum_valid}, 32'h0);
    checkOutput("reset_sum_data", sum_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(9, 32'h3F800000);
    applyStimulus(1'b0, 1'b1, 32'h41100000);

    win_terms.push_back(32'h41A00000);
    win_terms.push_back(32'hC1A00000);
    fill(7, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h00000000);

    sink_delay = 5;
    fill(9, 32'h3F800000);
    applyStimulus(1'b0, 1'b1, 32'h41100000);
    fill(9, 32'h3F800000);
    applyStimulus(1'b0, 1'b1, 32'h41100000);
    sink_delay = 0;

    fill(4, 32'h3F800000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    model_acc = 32'h0;
    model_cnt = 0;
    #2;
    checkOutput("midreset_sum_valid", {31'h0, sum_valid}, 32'h0);
    checkOutput("midreset_sum_data", sum_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill(9, 32'h3F800000);
    applyStimulus(1'b0, 1'b1, 32'h41100000);

    win_terms.push_back(32'h00000001);
    fill(8, 32'h40000000);
    applyStimulus(1'b0, 1'b1, 32'h41800000);

    fill(3, 32'hBF800000);
    fill(6, 32'h0);
`ifdef FLOAT_ACC_RELU_EN
    applyStimulus(1'b0, 1'b1, 32'h00000000);
`else
    applyStimulus(1'b0, 1'b1, 32'hC0400000);
`endif

    fill(2, 32'h7F7FFFFF);
    fill(7, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h7F800000);

    win_terms.push_back(32'h00800001);
    win_terms.push_back(32'h80800000);
    fill(7, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h00000000);

    for (int w = 0; w < 40; w++) begin
      sink_delay = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) win_terms.push_back(rand_term());
      applyStimulus(1'b1, 1'b0, 32'h0);
    end

    waited = 0;
    while ((exp_q.size() != 0 || sum_valid) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("drain_queue", 32'(exp_q.size()), 32'h0);
    checkOutput("output_count", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
